// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;
    localparam int NUM_IRQ    = 4;
    localparam int ID_W       = $clog2(NUM_IRQ);
    localparam int NEST_DEPTH = 2;
    localparam logic [NUM_IRQ-1:0] EN_RST = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } irq_state_t;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Latency: combinational.
// Backpressure: none.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [ID_W-1:0]    idx,
    output logic               vld
);
    always_comb begin
        idx = '0;
        vld = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with enable mask and in-service tracking; IRQ_NESTING_EN adds 2-deep preemption.
// Latency: source edge to ExtIRQ is 1 cycle; enable writes take effect the following cycle.
// Backpressure: requests stay pending until the processor acks with ExcAck.
module irq_controller
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    input  logic               ExcAck,
    input  logic               ERet,
    output logic               ExtIRQ,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] irq_cause,
    output logic               in_handler
);
    irq_state_t         state, state_nxt;
    logic [NUM_IRQ-1:0] src_q, pending, enable;
    logic [NUM_IRQ-1:0] rise, clr, en_nxt, cause_nxt;
    logic               cand_vld, any_nxt;

    assign rise   = irq_src & ~src_q;
    assign en_nxt = en_we ? en_wdata : enable;
    // Clears only happen on the ack path, which leaves IDLE/PEND regardless,
    // so the post-edge decision can ignore them.
    assign any_nxt = |((pending | rise) & en_nxt);

    irq_prio_enc u_enc (
        .req (pending & enable),
        .idx (irq_id),
        .vld (cand_vld)
    );

`ifdef IRQ_NESTING_EN
    logic [NUM_IRQ-1:0] stack [NEST_DEPTH];
    logic [1:0]         depth;
    logic [ID_W-1:0]    act_idx;
    logic               act_vld, nest_ok, push, pop;

    irq_prio_enc u_act (
        .req (irq_cause),
        .idx (act_idx),
        .vld (act_vld)
    );

    assign nest_ok = (state == ACTIVE) && cand_vld && act_vld &&
                     (irq_id < act_idx) && (depth < 2'(NEST_DEPTH));
    assign ExtIRQ  = (state == PEND) || nest_ok;
`else
    assign ExtIRQ  = (state == PEND);
`endif

    assign in_handler = |irq_cause;

    always_comb begin
        state_nxt = state;
        cause_nxt = irq_cause;
        clr       = '0;
`ifdef IRQ_NESTING_EN
        push = 1'b0;
        pop  = 1'b0;
`endif
        case (state)
            IDLE: if (any_nxt) state_nxt = PEND;
            PEND: begin
                if (ExcAck && cand_vld) begin
                    clr       = onehot(irq_id);
                    cause_nxt = onehot(irq_id);
                    state_nxt = ACTIVE;
                end else if (!any_nxt) begin
                    state_nxt = IDLE;
                end
            end
            ACTIVE: begin
`ifdef IRQ_NESTING_EN
                if (ExcAck && nest_ok) begin
                    clr       = onehot(irq_id);
                    cause_nxt = onehot(irq_id);
                    push      = 1'b1;
                end else if (ERet && depth != 2'd0) begin
                    cause_nxt = stack[~depth[0]];
                    pop       = 1'b1;
                end else if (ERet) begin
`else
                if (ERet) begin
`endif
                    cause_nxt = '0;
                    state_nxt = any_nxt ? PEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_q     <= '0;
            pending   <= '0;
            enable    <= EN_RST;
            irq_cause <= '0;
        end else begin
            state     <= state_nxt;
            src_q     <= irq_src;
            pending   <= (pending & ~clr) | rise;
            enable    <= en_nxt;
            irq_cause <= cause_nxt;
        end
    end

`ifdef IRQ_NESTING_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
        end else if (push) begin
            stack[depth[0]] <= irq_cause;
            depth           <= depth + 2'd1;
        end else if (pop) begin
            depth <= depth - 2'd1;
        end
    end
`endif
endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a behavioural model.
module tb_irq_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic       en_we;
    logic [3:0] en_wdata;
    logic       ExcAck;
    logic       ERet;
    logic       ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] irq_cause;
    logic       in_handler;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending set, enable mask, last source sample, source in service (-1 = none)
    logic [3:0] m_pend, m_en, m_prev;
    int         m_act;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .en_we      (en_we),
        .en_wdata   (en_wdata),
        .ExcAck     (ExcAck),
        .ERet       (ERet),
        .ExtIRQ     (ExtIRQ),
        .irq_id     (irq_id),
        .irq_cause  (irq_cause),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic m_ext();
        return (m_act < 0) && ((m_pend & m_en) != 4'b0);
    endfunction

    task automatic model_edge();
        logic [3:0] clr;
        clr = 4'b0;
        if (reset) begin
            m_pend = 4'b0; m_en = 4'b1111; m_prev = 4'b0; m_act = -1;
        end else begin
            if (ExcAck && m_ext()) begin
                m_act = lowest(m_pend & m_en);
                clr   = 4'b1 << m_act;
            end else if (ERet && m_act >= 0) begin
                m_act = -1;
            end
            m_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
            if (en_we) m_en = en_wdata;
            m_prev = irq_src;
        end
    endtask

    task automatic step(input logic [3:0] s, input logic we, input logic [3:0] wd,
                        input logic ack, input logic er, input logic rst);
        irq_src = s; en_we = we; en_wdata = wd; ExcAck = ack; ERet = er; reset = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ext_irq",    8'(ExtIRQ),     8'(m_ext()));
        chk("irq_id",     8'(irq_id),     8'(lowest(m_pend & m_en)));
        chk("irq_cause",  8'(irq_cause),  (m_act >= 0) ? 8'(4'b1 << m_act) : 8'h0);
        chk("in_handler", 8'(in_handler), 8'(m_act >= 0));
    endtask

    initial begin
        logic [3:0] cur;
        m_pend = 4'b0; m_en = 4'b1111; m_prev = 4'b0; m_act = -1;
        @(negedge clk);
        step(4'b0000, 0, 4'h0, 0, 0, 1);
        chk("rst_ext", 8'(ExtIRQ), 8'h0);
        chk("rst_cause", 8'(irq_cause), 8'h0);

        // single source 2: request, accept, return
        step(4'b0100, 0, 4'h0, 0, 0, 0);
        chk("s2_ext", 8'(ExtIRQ), 8'h1);
        chk("s2_id", 8'(irq_id), 8'h2);
        step(4'b0100, 0, 4'h0, 1, 0, 0);
        chk("s2_cause", 8'(irq_cause), 8'h4);
        chk("s2_ext_act", 8'(ExtIRQ), 8'h0);
        step(4'b0000, 0, 4'h0, 0, 1, 0);
        chk("s2_done", 8'(in_handler), 8'h0);

        // simultaneous edges on 3 and 1: 1 first, then 3
        step(4'b1010, 0, 4'h0, 0, 0, 0);
        chk("p31_id", 8'(irq_id), 8'h1);
        step(4'b1010, 0, 4'h0, 1, 0, 0);
        chk("p31_cause", 8'(irq_cause), 8'h2);
        step(4'b0000, 0, 4'h0, 0, 1, 0);
        chk("p31_ext", 8'(ExtIRQ), 8'h1);
        chk("p31_id3", 8'(irq_id), 8'h3);
        step(4'b0000, 0, 4'h0, 1, 0, 0);
        step(4'b0000, 0, 4'h0, 0, 1, 0);

        // masked source 0, then unmask
        step(4'b0000, 1, 4'b1110, 0, 0, 0);
        step(4'b0001, 0, 4'h0, 0, 0, 0);
        chk("mask_ext", 8'(ExtIRQ), 8'h0);
        step(4'b0001, 1, 4'b1111, 0, 0, 0);
        chk("unmask_ext", 8'(ExtIRQ), 8'h1);
        chk("unmask_id", 8'(irq_id), 8'h0);

        // reset in ACTIVE with source 3 pending
        step(4'b0001, 0, 4'h0, 1, 0, 0);
        step(4'b1001, 0, 4'h0, 0, 0, 0);
        chk("pre_rst_cause", 8'(irq_cause), 8'h1);
        step(4'b0000, 0, 4'h0, 0, 0, 1);
        chk("abort_ext", 8'(ExtIRQ), 8'h0);
        chk("abort_hdl", 8'(in_handler), 8'h0);
        for (int i = 0; i < 3; i++) step(4'b0000, 0, 4'h0, 1, 1, 0);

        // randomized traffic
        cur = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            cur = cur ^ (4'($urandom) & 4'($urandom));
            step(cur, ($urandom_range(0, 11) == 0), 4'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
